// File: rtl/vae_pkg.sv
// ---------------------------------------------------------------------------
// vae_pkg
// Shared definitions for the VAE classifier feed path.
//   FRAC_BITS / ONE / THRESH_2_0 : Q6.10 fixed-point reference constants.
//   feeder_state_t               : control FSM state encoding of the feeder.
// ---------------------------------------------------------------------------
package vae_pkg;

    localparam int FRAC_BITS = 10;
    localparam logic signed [15:0] ONE        = 16'sd1024;
    localparam logic signed [15:0] THRESH_2_0 = 16'sd2048;

    typedef enum logic [2:0] {
        ST_FILL  = 3'd0,
        ST_START = 3'd1,
        ST_FEED  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_CLEAR = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/vae_classifier_feeder_feature_bank.sv
// ---------------------------------------------------------------------------
// feature_bank
// Three-vector x N_FEAT-word register buffer for one classifier batch.
//   clk, rst   : clock, synchronous active-low reset (clears data and lengths)
//   we         : write strobe for buf[wr_vec][wr_elem] <= wr_data
//   clr_len    : forget all stored lengths (data is left in place)
//   rd_idx     : feature index read on all three vectors in parallel
//   rd_data    : [v] = buf[v][rd_idx] if rd_idx < len[v], else 0
// ---------------------------------------------------------------------------
module feature_bank
    import vae_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int N_FEAT     = 10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          we,
    input  logic [1:0]                    wr_vec,
    input  logic [$clog2(N_FEAT)-1:0]     wr_elem,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          clr_len,
    input  logic [$clog2(N_FEAT)-1:0]     rd_idx,
    output logic [2:0][DATA_WIDTH-1:0]    rd_data
);

    localparam int AW = $clog2(N_FEAT);
    localparam int LW = $clog2(N_FEAT + 1);

    for (genvar gi = 0; gi < 3; gi++) begin : g_vec
        logic [DATA_WIDTH-1:0] mem_q [N_FEAT];
        logic [LW-1:0]         len_q;
        logic [LW-1:0]         len_d;
        logic                  wr_hit;

        assign wr_hit = we && (wr_vec == 2'(gi));

        // Length tracks the highest element written so far, so a vector that
        // closes early leaves stale words beyond its length masked off.
        always_comb begin
            len_d = len_q;
            if (clr_len) begin
                len_d = '0;
            end else if (wr_hit) begin
                len_d = LW'(wr_elem) + LW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                len_q <= '0;
                for (int i = 0; i < N_FEAT; i++) begin
                    mem_q[i] <= '0;
                end
            end else begin
                len_q <= len_d;
                if (wr_hit) begin
                    mem_q[wr_elem] <= wr_data;
                end
            end
        end

        assign rd_data[gi] = (LW'(rd_idx) < len_q) ? mem_q[rd_idx] : '0;
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, AW[0]};

endmodule

// File: rtl/vae_classifier_feeder.sv
// ---------------------------------------------------------------------------
// vae_classifier_feeder
// Collects three latent vectors from the encoder stream, then drives the
// three-lane classifier: start pulse, lock-step x1j/x2j/x3j/wj feed, wait for
// done (or time out), clr pulse, and re-arm.
//   clk, rst                  : clock, synchronous active-low reset
//   s_valid/s_ready/s_data/s_last : encoder feature stream (accepted in FILL)
//   w_we/w_addr/w_data/b_we   : weight / bias register writes (FILL only)
//   start, clr                : one-cycle classifier control pulses
//   x1j,x2j,x3j,wj,b1         : classifier operands (b1 static)
//   done, unhealthy           : classifier completion and decision
//   res_valid, res_unhealthy  : batch result pulse and held decision
//   busy, err_len, err_timeout: status (errors sticky until reset)
// ---------------------------------------------------------------------------
module vae_classifier_feeder
    import vae_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int N_FEAT      = 10,
    parameter int FEED_OFFSET = 1,
    parameter int TIMEOUT     = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_WIDTH-1:0]         s_data,
    input  logic                          s_last,
    input  logic                          w_we,
    input  logic [$clog2(N_FEAT)-1:0]     w_addr,
    input  logic [DATA_WIDTH-1:0]         w_data,
    input  logic                          b_we,
    output logic                          start,
    output logic                          clr,
    output logic [DATA_WIDTH-1:0]         x1j,
    output logic [DATA_WIDTH-1:0]         x2j,
    output logic [DATA_WIDTH-1:0]         x3j,
    output logic [DATA_WIDTH-1:0]         wj,
    output logic [DATA_WIDTH-1:0]         b1,
    input  logic                          done,
    input  logic                          unhealthy,
    output logic                          res_valid,
    output logic                          res_unhealthy,
    output logic                          busy,
    output logic                          err_len,
    output logic                          err_timeout
);

    localparam int AW       = $clog2(N_FEAT);
    localparam int FEED_LEN = FEED_OFFSET + N_FEAT - 1;
    localparam int KW       = (FEED_LEN > 1) ? $clog2(FEED_LEN) : 1;
    localparam int TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    feeder_state_t         state_q, state_d;
    logic [1:0]            vec_q, vec_d;
    logic [AW-1:0]         elem_q, elem_d;
    logic                  drop_q, drop_d;
    logic [KW-1:0]         k_q, k_d;
    logic [TW-1:0]         wait_q, wait_d;
    logic                  s_ready_q, s_ready_d;
    logic                  start_q, start_d;
    logic                  clr_q, clr_d;
    logic                  res_valid_q, res_valid_d;
    logic                  res_unh_q, res_unh_d;
    logic                  err_len_q, err_len_d;
    logic                  err_to_q, err_to_d;
    logic [DATA_WIDTH-1:0] w_q [N_FEAT];
    logic [DATA_WIDTH-1:0] w_d [N_FEAT];
    logic [DATA_WIDTH-1:0] bias_q, bias_d;

    logic                  beat, last_pos, bank_we, bank_clr, cfg_wr;
    int                    feed_j;
    logic                  feed_hit;
    logic [AW-1:0]         rd_idx;
    logic [2:0][DATA_WIDTH-1:0] bank_rd;

    feature_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .N_FEAT     (N_FEAT)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (bank_we),
        .wr_vec  (vec_q),
        .wr_elem (elem_q),
        .wr_data (s_data),
        .clr_len (bank_clr),
        .rd_idx  (rd_idx),
        .rd_data (bank_rd)
    );

    // Weight and bias file: writable only while filling, so a batch in flight
    // always sees a stable operand set.
    assign cfg_wr = (state_q == ST_FILL);
    for (genvar gi = 0; gi < N_FEAT; gi++) begin : g_w
        assign w_d[gi] = (cfg_wr && w_we && (w_addr == AW'(gi))) ? w_data : w_q[gi];
        always_ff @(posedge clk) begin
            if (!rst) w_q[gi] <= '0;
            else      w_q[gi] <= w_d[gi];
        end
    end
    assign bias_d = (cfg_wr && b_we) ? w_data : bias_q;

    // Feed index lags the FEED cycle count so that index 0 lands exactly
    // FEED_OFFSET cycles after the start pulse; leading slots drive zero.
    always_comb begin
        feed_j   = int'(k_q) - (FEED_OFFSET - 1);
        feed_hit = (state_q == ST_FEED) && (feed_j >= 0) && (feed_j < N_FEAT);
        rd_idx   = feed_hit ? feed_j[AW-1:0] : '0;
    end

    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        elem_d      = elem_q;
        drop_d      = drop_q;
        k_d         = k_q;
        wait_d      = wait_q;
        res_valid_d = 1'b0;
        res_unh_d   = res_unh_q;
        err_len_d   = err_len_q;
        err_to_d    = err_to_q;
        bank_we     = 1'b0;
        bank_clr    = 1'b0;
        beat        = s_valid && s_ready_q;
        last_pos    = (elem_q == AW'(N_FEAT - 1));

        case (state_q)
            ST_FILL: begin
                if (beat) begin
                    if (drop_q) begin
                        // Tail of an over-long vector: swallow up to s_last.
                        if (s_last) drop_d = 1'b0;
                    end else begin
                        bank_we = 1'b1;
                        if (s_last != last_pos) err_len_d = 1'b1;
                        if (last_pos && !s_last) drop_d = 1'b1;
                        if (s_last || last_pos) begin
                            elem_d = '0;
                            if (vec_q == 2'd2) begin
                                vec_d   = 2'd0;
                                state_d = ST_START;
                            end else begin
                                vec_d = vec_q + 2'd1;
                            end
                        end else begin
                            elem_d = elem_q + AW'(1);
                        end
                    end
                end
            end
            ST_START: begin
                k_d     = '0;
                state_d = ST_FEED;
            end
            ST_FEED: begin
                if (k_q == KW'(FEED_LEN - 1)) begin
                    wait_d  = '0;
                    state_d = ST_WAIT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_WAIT: begin
                if (done) begin
                    res_unh_d   = unhealthy;
                    res_valid_d = 1'b1;
                    state_d     = ST_CLEAR;
                end else if (wait_q == TW'(TIMEOUT - 1)) begin
                    err_to_d = 1'b1;
                    state_d  = ST_CLEAR;
                end else begin
                    wait_d = wait_q + TW'(1);
                end
            end
            ST_CLEAR: begin
                bank_clr = 1'b1;
                vec_d    = 2'd0;
                elem_d   = '0;
                state_d  = ST_FILL;
            end
            default: state_d = ST_FILL;
        endcase

        // Control outputs are registered from the next state so they line
        // up with the state they belong to.
        s_ready_d = (state_d == ST_FILL);
        start_d   = (state_d == ST_START);
        clr_d     = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_FILL;
            vec_q       <= '0;
            elem_q      <= '0;
            drop_q      <= 1'b0;
            k_q         <= '0;
            wait_q      <= '0;
            s_ready_q   <= 1'b0;
            start_q     <= 1'b0;
            clr_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_unh_q   <= 1'b0;
            err_len_q   <= 1'b0;
            err_to_q    <= 1'b0;
            bias_q      <= '0;
        end else begin
            state_q     <= state_d;
            vec_q       <= vec_d;
            elem_q      <= elem_d;
            drop_q      <= drop_d;
            k_q         <= k_d;
            wait_q      <= wait_d;
            s_ready_q   <= s_ready_d;
            start_q     <= start_d;
            clr_q       <= clr_d;
            res_valid_q <= res_valid_d;
            res_unh_q   <= res_unh_d;
            err_len_q   <= err_len_d;
            err_to_q    <= err_to_d;
            bias_q      <= bias_d;
        end
    end

    assign s_ready       = s_ready_q;
    assign start         = start_q;
    assign clr           = clr_q;
    assign res_valid     = res_valid_q;
    assign res_unhealthy = res_unh_q;
    assign err_len       = err_len_q;
    assign err_timeout   = err_to_q;
    assign busy          = (state_q != ST_FILL);
    assign b1            = bias_q;
    assign x1j           = feed_hit ? bank_rd[0] : '0;
    assign x2j           = feed_hit ? bank_rd[1] : '0;
    assign x3j           = feed_hit ? bank_rd[2] : '0;
    assign wj            = feed_hit ? w_q[rd_idx] : '0;

endmodule

// File: tb/tb_vae_classifier_feeder.sv
module tb_vae_classifier_feeder;

    localparam int DW   = 16;
    localparam int N    = 10;
    localparam int FO   = 1;
    localparam int TO   = 32;
    localparam int DONE_DLY = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_data;
    logic          w_we, b_we;
    logic [3:0]    w_addr;
    logic [DW-1:0] w_data;
    logic          start, clr, done, unhealthy;
    logic [DW-1:0] x1j, x2j, x3j, wj, b1;
    logic          res_valid, res_unhealthy, busy, err_len, err_timeout;

    vae_classifier_feeder #(
        .DATA_WIDTH(DW), .N_FEAT(N), .FEED_OFFSET(FO), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .b_we(b_we),
        .start(start), .clr(clr),
        .x1j(x1j), .x2j(x2j), .x3j(x3j), .wj(wj), .b1(b1),
        .done(done), .unhealthy(unhealthy),
        .res_valid(res_valid), .res_unhealthy(res_unhealthy),
        .busy(busy), .err_len(err_len), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Reference model: what the classifier should see for this batch.
    int            checks = 0;
    int            errors = 0;
    int            d;
    int            vlen [3];
    logic [DW-1:0] vdata [3][16];
    logic [DW-1:0] wm [N];
    logic [DW-1:0] bias_m;
    logic          exp_err_len, exp_err_to, exp_unh;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic w_write(input int idx, input logic [DW-1:0] val, input bit also_bias);
        w_we = 1'b1; b_we = also_bias; w_addr = 4'(idx); w_data = val;
        step();
        w_we = 1'b0; b_we = 1'b0;
        wm[idx] = val;
        if (also_bias) bias_m = val;
    endtask

    task automatic b_write(input logic [DW-1:0] val);
        b_we = 1'b1; w_data = val;
        step();
        b_we = 1'b0;
        bias_m = val;
    endtask

    function automatic logic [DW-1:0] exp_x(input int v, input int j);
        int stored;
        stored = (vlen[v] < N) ? vlen[v] : N;
        return (j >= 0 && j < stored) ? vdata[v][j] : '0;
    endfunction

    task automatic stream(input bit gaps);
        int guard;
        for (int v = 0; v < 3; v++) begin
            if (vlen[v] != N) exp_err_len = 1'b1;
            for (int e = 0; e < vlen[v]; e++) begin
                if (gaps) begin
                    s_valid = 1'b0;
                    step();
                end
                s_valid = 1'b1;
                s_data  = vdata[v][e];
                s_last  = (e == vlen[v] - 1);
                guard   = 0;
                while (s_ready !== 1'b1 && guard < 50) begin
                    step();
                    guard++;
                end
                if (guard >= 50) chk("s_ready_wait", {15'd0, s_ready}, 16'd1);
                step();
            end
        end
        s_valid = 1'b0; s_last = 1'b0;
        chk("start_after_last", {15'd0, start}, 16'd1);
        chk("s_ready_in_start", {15'd0, s_ready}, 16'd0);
        chk("busy_in_start", {15'd0, busy}, 16'd1);
        chk("err_len", {15'd0, err_len}, {15'd0, exp_err_len});
        d = 0;
    endtask

    task automatic feed_check(input bit wr_during_feed);
        int j;
        for (int c = 1; c <= FO + N; c++) begin
            step();
            d = c;
            j = c - FO;
            if (c == 1) chk("start_pulse_end", {15'd0, start}, 16'd0);
            chk($sformatf("x1j[%0d]", j), x1j, exp_x(0, j));
            chk($sformatf("x2j[%0d]", j), x2j, exp_x(1, j));
            chk($sformatf("x3j[%0d]", j), x3j, exp_x(2, j));
            chk($sformatf("wj[%0d]", j), wj, (j >= 0 && j < N) ? wm[j] : 16'd0);
            chk("b1", b1, bias_m);
            if (wr_during_feed && c == 2) begin
                w_we = 1'b1; b_we = 1'b1; w_addr = 4'd2; w_data = 16'h7fff;
            end
            if (c == 3) begin
                w_we = 1'b0; b_we = 1'b0;
            end
        end
    endtask

    task automatic finish_done(input logic unh);
        while (d < DONE_DLY) begin
            step();
            d++;
        end
        chk("res_valid_pre", {15'd0, res_valid}, 16'd0);
        chk("clr_pre", {15'd0, clr}, 16'd0);
        done = 1'b1; unhealthy = unh;
        step();
        done = 1'b0; unhealthy = ~unh;
        exp_unh = unh;
        chk("res_valid", {15'd0, res_valid}, 16'd1);
        chk("clr", {15'd0, clr}, 16'd1);
        chk("res_unhealthy", {15'd0, res_unhealthy}, {15'd0, exp_unh});
        step();
        chk("s_ready_rearm", {15'd0, s_ready}, 16'd1);
        chk("res_valid_end", {15'd0, res_valid}, 16'd0);
        chk("clr_end", {15'd0, clr}, 16'd0);
        chk("busy_rearm", {15'd0, busy}, 16'd0);
        chk("res_unhealthy_hold", {15'd0, res_unhealthy}, {15'd0, exp_unh});
    endtask

    task automatic finish_timeout();
        while (d < FO + N + TO - 1) begin
            step();
            d++;
        end
        chk("err_timeout_pre", {15'd0, err_timeout}, {15'd0, exp_err_to});
        chk("clr_pre_to", {15'd0, clr}, 16'd0);
        step();
        exp_err_to = 1'b1;
        chk("err_timeout", {15'd0, err_timeout}, 16'd1);
        chk("clr_to", {15'd0, clr}, 16'd1);
        chk("res_valid_to", {15'd0, res_valid}, 16'd0);
        step();
        chk("s_ready_after_to", {15'd0, s_ready}, 16'd1);
        chk("res_unhealthy_keep", {15'd0, res_unhealthy}, {15'd0, exp_unh});
    endtask

    task automatic rand_vectors(input int l0, input int l1, input int l2);
        vlen[0] = l0; vlen[1] = l1; vlen[2] = l2;
        for (int v = 0; v < 3; v++)
            for (int e = 0; e < 16; e++)
                vdata[v][e] = DW'($urandom());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        w_we = 1'b0; b_we = 1'b0; w_addr = '0; w_data = '0;
        done = 1'b0; unhealthy = 1'b0;
        exp_err_len = 1'b0; exp_err_to = 1'b0; exp_unh = 1'b0; bias_m = '0;
        for (int j = 0; j < N; j++) wm[j] = '0;
        repeat (3) step();
        chk("rst_s_ready", {15'd0, s_ready}, 16'd0);
        chk("rst_start", {15'd0, start}, 16'd0);
        chk("rst_clr", {15'd0, clr}, 16'd0);
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_b1", b1, 16'd0);
        chk("rst_x1j", x1j, 16'd0);
        chk("rst_res_valid", {15'd0, res_valid}, 16'd0);
        chk("rst_err", {14'd0, err_len, err_timeout}, 16'd0);
        rst = 1'b1;
        step();
        chk("first_fill_s_ready", {15'd0, s_ready}, 16'd1);

        // Batch 1: nominal ramp data and weights, classifier says unhealthy.
        for (int j = 0; j < N; j++) w_write(j, DW'(j * 64), 1'b0);
        b_write(16'sd512);
        vlen[0] = N; vlen[1] = N; vlen[2] = N;
        for (int v = 0; v < 3; v++)
            for (int e = 0; e < 16; e++) vdata[v][e] = DW'((v + 1) * e);
        stream(1'b0); feed_check(1'b0); finish_done(1'b1);
        $display("batch 1 nominal: checks=%0d", checks);

        // Batch 2: vector 1 closes after 7 words.
        rand_vectors(N, 7, N);
        stream(1'b0); feed_check(1'b0); finish_done(1'($urandom_range(0, 1)));
        $display("batch 2 short vector: checks=%0d", checks);

        // Batch 3: combined weight+bias write, gapped stream, ignored FEED write.
        w_write(5, DW'($urandom()), 1'b1);
        rand_vectors(N, N, N);
        stream(1'b1); feed_check(1'b1); finish_done(1'($urandom_range(0, 1)));
        $display("batch 3 backpressure: checks=%0d", checks);

        // Batch 4: classifier never answers; weights must be unchanged.
        rand_vectors(N, N, N);
        stream(1'b0); feed_check(1'b0); finish_timeout();
        $display("batch 4 timeout: checks=%0d", checks);

        // Batch 5: over-long vector 0, tail words dropped.
        rand_vectors(12, N, N);
        stream(1'b0); feed_check(1'b0); finish_done(1'($urandom_range(0, 1)));
        $display("batch 5 long vector: checks=%0d", checks);

        // Batch 6: reset in the middle of FEED.
        rand_vectors(N, N, N);
        stream(1'b0);
        repeat (3) step();
        rst = 1'b0;
        step();
        chk("mid_rst_start", {15'd0, start}, 16'd0);
        chk("mid_rst_clr", {15'd0, clr}, 16'd0);
        chk("mid_rst_res_valid", {15'd0, res_valid}, 16'd0);
        chk("mid_rst_x2j", x2j, 16'd0);
        chk("mid_rst_wj", wj, 16'd0);
        chk("mid_rst_busy", {15'd0, busy}, 16'd0);
        chk("mid_rst_err", {14'd0, err_len, err_timeout}, 16'd0);
        rst = 1'b1;
        exp_err_len = 1'b0; exp_err_to = 1'b0; exp_unh = 1'b0; bias_m = '0;
        for (int j = 0; j < N; j++) wm[j] = '0;
        step();
        chk("mid_rst_s_ready", {15'd0, s_ready}, 16'd1);
        $display("batch 6 reset mid-feed: checks=%0d", checks);

        // Batch 7: normal operation after reset, with a short vector 2.
        for (int j = 0; j < N; j++) w_write(j, DW'($urandom()), 1'b0);
        b_write(DW'($urandom()));
        rand_vectors(N, N, 4);
        stream(1'b1); feed_check(1'b0); finish_done(1'($urandom_range(0, 1)));
        $display("batch 7 post-reset: checks=%0d", checks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
